// File: rtl/banco_temporizadores_if.sv
// Timer-bank bus: the seven timer-request levels coming from the drink-machine FSM,
// the seven timeout levels going back to it, and the display outputs.
//   master : drives the sec* requests, reads T*, restante and ocupado
//   slave  : the timer bank itself
interface banco_temporizadores_if #(
   parameter int SEC_W = 4
);
   logic             sec10_bebida;
   logic             sec10_moeda;
   logic             sec2_pressu;
   logic             sec10_aqueci;
   logic             sec2_entre;
   logic             sec6_errMoeda;
   logic             sec6_sensor;
   logic             T10_bebida;
   logic             T10_moeda;
   logic             T2_pressu;
   logic             T10_aqueci;
   logic             T2_entre;
   logic             T6_errMoeda;
   logic             T6_sensor;
   logic [SEC_W-1:0] restante;
   logic             ocupado;

   modport master (
      output sec10_bebida, sec10_moeda, sec2_pressu, sec10_aqueci,
             sec2_entre, sec6_errMoeda, sec6_sensor,
      input  T10_bebida, T10_moeda, T2_pressu, T10_aqueci,
             T2_entre, T6_errMoeda, T6_sensor, restante, ocupado
   );

   modport slave (
      input  sec10_bebida, sec10_moeda, sec2_pressu, sec10_aqueci,
             sec2_entre, sec6_errMoeda, sec6_sensor,
      output T10_bebida, T10_moeda, T2_pressu, T10_aqueci,
             T2_entre, T6_errMoeda, T6_sensor, restante, ocupado
   );
endinterface

// File: rtl/banco_temporizadores.sv
// Timer bank for the drink-machine control FSM. Seven independent channels, each
// with its own prescaler and seconds counter, turn a request level into a timeout
// level after a fixed number of seconds. Also exports the seconds remaining on the
// lowest-index counting channel for the display.
// Ports:
//   clock : system clock, all logic on posedge
//   reset : asynchronous, active-high
//   bus   : slave side of banco_temporizadores_if (sec* in, T*/restante/ocupado out)
//
// Channel states:
//   state    | meaning
//   IDLE     | request low, counters cleared, T = 0
//   COUNTING | request high, prescaler and seconds running
//   DONE     | duration reached, T = 1 until request drops
module banco_temporizadores #(
   parameter int CLK_HZ       = 50000000,
   parameter int DUR_BEBIDA   = 10,
   parameter int DUR_MOEDA    = 10,
   parameter int DUR_PRESSU   = 2,
   parameter int DUR_AQUECI   = 10,
   parameter int DUR_ENTRE    = 2,
   parameter int DUR_ERRMOEDA = 6,
   parameter int DUR_SENSOR   = 6,
   parameter int SEC_W        = 4
) (
   input logic                   clock,
   input logic                   reset,
   banco_temporizadores_if.slave bus
);
   localparam int NCH   = 7;
   localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

   typedef enum logic [1:0] {IDLE, COUNTING, DONE} st_t;

   function automatic logic [SEC_W-1:0] dur_of(input int ch);
      case (ch)
         0:       return SEC_W'(DUR_BEBIDA);
         1:       return SEC_W'(DUR_MOEDA);
         2:       return SEC_W'(DUR_PRESSU);
         3:       return SEC_W'(DUR_AQUECI);
         4:       return SEC_W'(DUR_ENTRE);
         5:       return SEC_W'(DUR_ERRMOEDA);
         default: return SEC_W'(DUR_SENSOR);
      endcase
   endfunction

   logic [NCH-1:0]   en;
   logic [NCH-1:0]   t;
   st_t              st  [NCH];
   logic [PRE_W-1:0] pre [NCH];
   logic [SEC_W-1:0] sec [NCH];
   logic [SEC_W-1:0] restante_nxt, restante_q;
   logic             ocupado_nxt, ocupado_q;

   assign en = {bus.sec6_sensor, bus.sec6_errMoeda, bus.sec2_entre, bus.sec10_aqueci,
                bus.sec2_pressu, bus.sec10_moeda, bus.sec10_bebida};

   // Scan from the top so the lowest-index counting channel is the one that sticks.
   always_comb begin
      restante_nxt = '0;
      ocupado_nxt  = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (st[i] == COUNTING) begin
            ocupado_nxt  = 1'b1;
            restante_nxt = dur_of(i) - sec[i];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            st[i]  <= IDLE;
            pre[i] <= '0;
            sec[i] <= '0;
         end
         t          <= '0;
         restante_q <= '0;
         ocupado_q  <= 1'b0;
      end else begin
         restante_q <= restante_nxt;
         ocupado_q  <= ocupado_nxt;
         for (int i = 0; i < NCH; i++) begin
            case (st[i])
               IDLE: begin
                  if (en[i]) begin
                     st[i]  <= COUNTING;
                     pre[i] <= '0;
                     sec[i] <= '0;
                  end
               end
               COUNTING: begin
                  // A dropped request wins over reaching the duration on the same edge.
                  if (!en[i]) begin
                     st[i]  <= IDLE;
                     pre[i] <= '0;
                     sec[i] <= '0;
                  end else if (pre[i] == PRE_LAST) begin
                     pre[i] <= '0;
                     if (sec[i] + 1'b1 == dur_of(i)) begin
                        st[i]  <= DONE;
                        sec[i] <= '0;
                        t[i]   <= 1'b1;
                     end else begin
                        sec[i] <= sec[i] + 1'b1;
                     end
                  end else begin
                     pre[i] <= pre[i] + 1'b1;
                  end
               end
               DONE: begin
                  if (!en[i]) begin
                     st[i] <= IDLE;
                     t[i]  <= 1'b0;
                  end
               end
               default: begin
                  st[i] <= IDLE;
                  t[i]  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.T10_bebida  = t[0];
   assign bus.T10_moeda   = t[1];
   assign bus.T2_pressu   = t[2];
   assign bus.T10_aqueci  = t[3];
   assign bus.T2_entre    = t[4];
   assign bus.T6_errMoeda = t[5];
   assign bus.T6_sensor   = t[6];
   assign bus.restante    = restante_q;
   assign bus.ocupado     = ocupado_q;
endmodule

// File: tb/tb_banco_temporizadores.sv
// Bench for banco_temporizadores. The driver applies request levels shortly after
// each rising edge and pushes the outputs the reference model predicts for that
// edge; the monitor pops and compares on the falling edge.
// Reference model: each channel is described only by how many consecutive edges
// its request has been seen high ("run"). A channel is counting while
// 1 <= run <= DUR*CLK_HZ, times out once run exceeds DUR*CLK_HZ, and has
// (run-1)/CLK_HZ whole seconds elapsed.
module tb_banco_temporizadores;
   localparam int CLK  = 4;
   localparam int SW   = 4;
   localparam int NCH  = 7;

   logic clock;
   logic reset;
   int   errors;
   int   checks;

   banco_temporizadores_if #(.SEC_W(SW)) bus ();

   banco_temporizadores #(.CLK_HZ(CLK), .SEC_W(SW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int             durs [NCH] = '{10, 10, 2, 10, 2, 6, 6};
   int             run  [NCH];
   logic [NCH-1:0] en_cur;
   logic [12:0]    sbq [$];
   int             cyc;

   function automatic logic [12:0] gather();
      return {bus.T6_sensor, bus.T6_errMoeda, bus.T2_entre, bus.T10_aqueci,
              bus.T2_pressu, bus.T10_moeda, bus.T10_bebida, bus.restante, bus.ocupado};
   endfunction

   task automatic drive(input logic [NCH-1:0] e);
      en_cur            = e;
      bus.sec10_bebida  = e[0];
      bus.sec10_moeda   = e[1];
      bus.sec2_pressu   = e[2];
      bus.sec10_aqueci  = e[3];
      bus.sec2_entre    = e[4];
      bus.sec6_errMoeda = e[5];
      bus.sec6_sensor   = e[6];
   endtask

   // Model what the coming edge does, then apply the next inputs.
   task automatic step(input logic [NCH-1:0] en_n, input logic rst_n);
      logic [NCH-1:0] tv;
      logic [SW-1:0]  rest;
      logic           ocup;
      logic           rst_was;
      logic [12:0]    act;
      @(posedge clock);
      cyc++;
      tv   = '0;
      rest = '0;
      ocup = 1'b0;
      if (reset) begin
         for (int c = 0; c < NCH; c++) run[c] = 0;
      end else begin
         for (int c = NCH - 1; c >= 0; c--) begin
            if (run[c] >= 1 && run[c] <= durs[c] * CLK) begin
               ocup = 1'b1;
               rest = SW'(durs[c] - (run[c] - 1) / CLK);
            end
         end
         for (int c = 0; c < NCH; c++) begin
            if (en_cur[c]) run[c] = (run[c] > durs[c] * CLK) ? run[c] : run[c] + 1;
            else           run[c] = 0;
            tv[c] = (run[c] > durs[c] * CLK);
         end
      end
      #2;
      rst_was = reset;
      drive(en_n);
      reset = rst_n;
      if (rst_n) begin
         for (int c = 0; c < NCH; c++) run[c] = 0;
         tv   = '0;
         rest = '0;
         ocup = 1'b0;
         if (!rst_was) begin
            #1;
            act = gather();
            checks++;
            if (act !== 13'd0) begin
               errors++;
               $display("FAIL async_reset cycle %0d: outputs %b, required all zero", cyc, act);
            end
         end
      end
      sbq.push_back({tv, rest, ocup});
   endtask

   task automatic hold(input logic [NCH-1:0] e, input int n);
      for (int k = 0; k < n; k++) step(e, 1'b0);
   endtask

   initial begin : monitor
      logic [12:0] exp_v;
      logic [12:0] act_v;
      forever begin
         @(negedge clock);
         if (sbq.size() > 0) begin
            exp_v = sbq.pop_front();
            act_v = gather();
            checks++;
            if (act_v !== exp_v) begin
               errors++;
               $display("FAIL outputs cycle %0d: T got %b want %b, restante got %0d want %0d, ocupado got %b want %b",
                        cyc, act_v[12:6], exp_v[12:6], act_v[5:2], exp_v[5:2], act_v[0], exp_v[0]);
            end
         end
      end
   end

   initial begin : stimulus
      logic [NCH-1:0] r;
      errors = 0;
      checks = 0;
      cyc    = 0;
      for (int c = 0; c < NCH; c++) run[c] = 0;
      reset = 1'b1;
      drive('0);

      repeat (3) step('0, 1'b1);
      step(7'h7F, 1'b0);
      // all channels running, then async reset with every request still high
      hold(7'h7F, 10);
      step(7'h7F, 1'b1);
      step(7'h7F, 1'b1);
      step('0, 1'b1);
      step('0, 1'b0);

      // short channel held, then released
      hold(7'b0000100, 12);
      hold('0, 3);

      // abort at 20 edges, gap of 3, full restart
      hold(7'b0000001, 20);
      hold('0, 3);
      hold(7'b0000001, 45);
      hold('0, 2);

      // handoff from ch0 to ch1 on one edge
      hold(7'b0000001, 10);
      hold(7'b0000010, 45);
      hold('0, 2);

      // concurrent ch3 and ch6
      hold(7'b1001000, 45);
      hold('0, 2);

      // reset pulse while ch5 is running and its request stays high
      hold(7'b0100000, 15);
      step(7'b0100000, 1'b1);
      hold(7'b0100000, 30);
      hold('0, 2);

      // random levels with rare resets
      r = '0;
      for (int k = 0; k < 600; k++) begin
         for (int c = 0; c < NCH; c++)
            if ($urandom_range(0, 15) == 0) r[c] = ~r[c];
         step(r, ($urandom_range(0, 199) == 0));
      end
      hold('0, 2);

      repeat (3) @(negedge clock);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
